sdram_loader_arb: RTL and testbench

Arbiter and sequencer for the single wishbone port of the SDRAM controller. It shares that port between the Archimedes core's memory master and the HPS ROM loader. On a RISC OS download it drains any in-flight core cycle, then zero-fills the low RAM region. After that it turns the host's 16-bit ioctl writes into 32-bit wishbone writes with byte-lane selects, and throttles the host through `dl_wait`. It also reports completion of the first full download, which the top level uses to release initial reset.

---
 rtl/sdram_loader_arb.sv | 197 +++++++++++++++++++
 tb/tb_sdram_loader_arb.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_loader_arb.sv
// ============================================================================
// sdram_loader_arb: shares the SDRAM wishbone port between the core and the
// ROM loader (drain, zero-fill, 16->32 bit download writes).  Rev 1.0
// ============================================================================
`default_nettype none

module sdram_loader_arb #(
  parameter int          ERASE_WORDS = 1048576,
  parameter logic [23:0] LOAD_BASE   = 24'h100000
) (
  input  logic        clk_sys,
  input  logic        reset_n,

  input  logic        dl_active,
  input  logic        dl_wr,
  input  logic [21:0] dl_addr,
  input  logic [15:0] dl_data,
  output logic        dl_wait,
  output logic        rom_loaded,

  input  logic        core_stb,
  input  logic        core_cyc,
  input  logic        core_we,
  input  logic [3:0]  core_sel,
  input  logic [21:0] core_adr,
  input  logic [31:0] core_dat,
  output logic        core_ack,

  output logic        ram_stb,
  output logic        ram_cyc,
  output logic        ram_we,
  output logic [3:0]  ram_sel,
  output logic [23:0] ram_adr,
  output logic [31:0] ram_dat,
  input  logic        ram_ack
);

  localparam int CNT_W = (ERASE_WORDS > 1) ? $clog2(ERASE_WORDS) : 1;
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(ERASE_WORDS - 1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_DRAIN     = 3'd1,
    ST_ERASE     = 3'd2,
    ST_LOAD      = 3'd3,
    ST_LOAD_BUSY = 3'd4,
    ST_FLUSH     = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  erase_cnt_q, erase_cnt_d;
  logic              abort_q, abort_d;
  logic              rom_loaded_q, rom_loaded_d;
  logic              dl_act_q, dl_rise_q, dl_fall_q;
  logic [23:0]       req_adr_q, req_adr_d;
  logic [31:0]       req_dat_q, req_dat_d;
  logic [3:0]        req_sel_q, req_sel_d;

  // Byte offset bit 0 has no meaning for 16-bit download words.
  logic unused_dl_addr_bit;
  assign unused_dl_addr_bit = dl_addr[0];

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      erase_cnt_q  <= '0;
      abort_q      <= 1'b0;
      rom_loaded_q <= 1'b0;
      dl_act_q     <= 1'b0;
      dl_rise_q    <= 1'b0;
      dl_fall_q    <= 1'b0;
      req_adr_q    <= '0;
      req_dat_q    <= '0;
      req_sel_q    <= '0;
    end else begin
      state_q      <= state_d;
      erase_cnt_q  <= erase_cnt_d;
      abort_q      <= abort_d;
      rom_loaded_q <= rom_loaded_d;
      dl_act_q     <= dl_active;
      dl_rise_q    <= dl_active & ~dl_act_q;
      dl_fall_q    <= ~dl_active & dl_act_q;
      req_adr_q    <= req_adr_d;
      req_dat_q    <= req_dat_d;
      req_sel_q    <= req_sel_d;
    end
  end

  assign rom_loaded = rom_loaded_q;

  always_comb begin
    state_d      = state_q;
    erase_cnt_d  = erase_cnt_q;
    abort_d      = abort_q;
    rom_loaded_d = rom_loaded_q;
    req_adr_d    = req_adr_q;
    req_dat_d    = req_dat_q;
    req_sel_d    = req_sel_q;

    ram_stb  = 1'b0;
    ram_cyc  = 1'b0;
    ram_we   = 1'b0;
    ram_sel  = 4'h0;
    ram_adr  = 24'h0;
    ram_dat  = 32'h0;
    core_ack = 1'b0;
    dl_wait  = 1'b0;

    case (state_q)
      ST_IDLE, ST_DRAIN: begin
        ram_stb  = core_stb;
        ram_cyc  = core_cyc;
        ram_we   = core_we;
        ram_sel  = core_sel;
        ram_adr  = {2'b00, core_adr};
        ram_dat  = core_dat;
        core_ack = ram_ack;
        if (state_q == ST_IDLE) begin
          erase_cnt_d = '0;
          abort_d     = 1'b0;
          if (dl_rise_q) begin
            state_d = core_cyc ? ST_DRAIN : ST_ERASE;
          end
        end else begin
          dl_wait = 1'b1;
          if (dl_fall_q) begin
            abort_d = 1'b1;
          end
          if (ram_ack) begin
            state_d = (abort_q || dl_fall_q) ? ST_IDLE : ST_ERASE;
          end
        end
      end

      ST_ERASE: begin
        ram_stb = 1'b1;
        ram_cyc = 1'b1;
        ram_we  = 1'b1;
        ram_sel = 4'hF;
        ram_adr = 24'(erase_cnt_q);
        dl_wait = 1'b1;
        if (dl_fall_q) begin
          abort_d = 1'b1;
        end
        if (ram_ack) begin
          if (abort_q || dl_fall_q) begin
            state_d = ST_IDLE;
          end else if (erase_cnt_q == LAST_WORD) begin
            state_d = ST_LOAD;
          end else begin
            erase_cnt_d = erase_cnt_q + 1'b1;
          end
        end
      end

      ST_LOAD: begin
        if (dl_wr) begin
          req_adr_d = LOAD_BASE | {4'h0, dl_addr[21:2]};
          req_dat_d = {dl_data, dl_data};
          req_sel_d = dl_addr[1] ? 4'b1100 : 4'b0011;
          // A write racing the end of the download still gets flushed.
          state_d   = dl_fall_q ? ST_FLUSH : ST_LOAD_BUSY;
        end else if (dl_fall_q) begin
          rom_loaded_d = 1'b1;
          state_d      = ST_IDLE;
        end
      end

      ST_LOAD_BUSY, ST_FLUSH: begin
        ram_stb = 1'b1;
        ram_cyc = 1'b1;
        ram_we  = 1'b1;
        ram_sel = req_sel_q;
        ram_adr = req_adr_q;
        ram_dat = req_dat_q;
        dl_wait = 1'b1;
        if (ram_ack) begin
          if (state_q == ST_FLUSH || dl_fall_q) begin
            rom_loaded_d = 1'b1;
            state_d      = ST_IDLE;
          end else begin
            state_d = ST_LOAD;
          end
        end else if (dl_fall_q) begin
          state_d = ST_FLUSH;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_sdram_loader_arb.sv
// ============================================================================
// tb_sdram_loader_arb: directed self-checking bench for sdram_loader_arb
// (ERASE_WORDS = 8).  Rev 1.0
// ============================================================================
`default_nettype none

module tb_sdram_loader_arb;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        dl_active, dl_wr;
  logic [21:0] dl_addr;
  logic [15:0] dl_data;
  logic        dl_wait, rom_loaded;
  logic        core_stb, core_cyc, core_we;
  logic [3:0]  core_sel;
  logic [21:0] core_adr;
  logic [31:0] core_dat;
  logic        core_ack;
  logic        ram_stb, ram_cyc, ram_we;
  logic [3:0]  ram_sel;
  logic [23:0] ram_adr;
  logic [31:0] ram_dat;
  logic        ram_ack;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_sys = ~clk_sys;

  // {stb, cyc, we, sel, adr, dat}
  logic [62:0] bus;
  assign bus = {ram_stb, ram_cyc, ram_we, ram_sel, ram_adr, ram_dat};

  sdram_loader_arb #(
    .ERASE_WORDS(8),
    .LOAD_BASE  (24'h100000)
  ) dut (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .dl_active (dl_active),
    .dl_wr     (dl_wr),
    .dl_addr   (dl_addr),
    .dl_data   (dl_data),
    .dl_wait   (dl_wait),
    .rom_loaded(rom_loaded),
    .core_stb  (core_stb),
    .core_cyc  (core_cyc),
    .core_we   (core_we),
    .core_sel  (core_sel),
    .core_adr  (core_adr),
    .core_dat  (core_dat),
    .core_ack  (core_ack),
    .ram_stb   (ram_stb),
    .ram_cyc   (ram_cyc),
    .ram_we    (ram_we),
    .ram_sel   (ram_sel),
    .ram_adr   (ram_adr),
    .ram_dat   (ram_dat),
    .ram_ack   (ram_ack)
  );

  task automatic test_reset();
    reset_n   = 1'b0;
    dl_active = 1'b0; dl_wr = 1'b0; dl_addr = '0; dl_data = '0;
    core_stb  = 1'b1; core_cyc = 1'b1; core_we = 1'b1;
    core_sel  = 4'h5; core_adr = 22'h2AAAA; core_dat = 32'hCAFEF00D;
    ram_ack   = 1'b1;
    repeat (2) @(negedge clk_sys);
    #1;
    n_checks++;
    if (bus !== {1'b1, 1'b1, 1'b1, 4'h5, 24'h02AAAA, 32'hCAFEF00D}) begin
      n_fail++; $display("FAIL reset_passthru: got %h want %h", bus,
                         {1'b1, 1'b1, 1'b1, 4'h5, 24'h02AAAA, 32'hCAFEF00D});
    end
    n_checks++;
    if ({core_ack, dl_wait, rom_loaded} !== 3'b100) begin
      n_fail++; $display("FAIL reset_flags: got ack/wait/loaded %b want 100",
                         {core_ack, dl_wait, rom_loaded});
    end
    core_stb = 1'b0; core_cyc = 1'b0; core_we = 1'b0; core_sel = 4'h0;
    core_adr = '0; core_dat = '0; ram_ack = 1'b0;
    @(negedge clk_sys);
    reset_n = 1'b1;
  endtask

  task automatic test_passthrough();
    @(negedge clk_sys);
    core_cyc = 1'b1; core_stb = 1'b1; core_we = 1'b0; core_sel = 4'hF;
    core_adr = 22'h12345;
    #1;
    n_checks++;
    if ({ram_stb, ram_cyc, ram_we, ram_adr, core_ack} !== {3'b110, 24'h012345, 1'b0}) begin
      n_fail++; $display("FAIL pass_read: got stb/cyc/we %b adr %h ack %b want 110 012345 0",
                         {ram_stb, ram_cyc, ram_we}, ram_adr, core_ack);
    end
    @(negedge clk_sys);
    ram_ack = 1'b1;
    #1;
    n_checks++;
    if (core_ack !== 1'b1) begin
      n_fail++; $display("FAIL pass_ack: got %b want 1", core_ack);
    end
    @(negedge clk_sys);
    ram_ack = 1'b0; core_cyc = 1'b0; core_stb = 1'b0;
    #1;
    n_checks++;
    if ({core_ack, dl_wait, rom_loaded, ram_stb} !== 4'b0000) begin
      n_fail++; $display("FAIL pass_after: got ack/wait/loaded/stb %b want 0000",
                         {core_ack, dl_wait, rom_loaded, ram_stb});
    end
  endtask

  task automatic test_erase();
    @(negedge clk_sys);
    dl_active = 1'b1;
    @(negedge clk_sys); #1;
    n_checks++;
    if ({ram_stb, dl_wait} !== 2'b00) begin
      n_fail++; $display("FAIL erase_latency: got stb/wait %b want 00", {ram_stb, dl_wait});
    end
    @(negedge clk_sys); #1;
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if ({bus, dl_wait} !== {3'b111, 4'hF, 24'(i), 32'h0, 1'b1}) begin
        n_fail++; $display("FAIL erase_word[%0d]: got %h wait %b want %h wait 1", i, bus,
                           dl_wait, {3'b111, 4'hF, 24'(i), 32'h0});
      end
      ram_ack = 1'b1;
      @(negedge clk_sys);
      ram_ack = 1'b0;
      #1;
      if (i < 7) begin
        n_checks++;
        if ({ram_stb, ram_adr} !== {1'b1, 24'(i + 1)}) begin
          n_fail++; $display("FAIL erase_hold[%0d]: got stb %b adr %h want 1 %h", i,
                             ram_stb, ram_adr, 24'(i + 1));
        end
        @(negedge clk_sys); #1;
      end
    end
    n_checks++;
    if ({ram_stb, dl_wait} !== 2'b00) begin
      n_fail++; $display("FAIL erase_done: got stb/wait %b want 00", {ram_stb, dl_wait});
    end
    @(negedge clk_sys); #1;
    n_checks++;
    if (ram_stb !== 1'b0) begin
      n_fail++; $display("FAIL erase_no_ninth: got stb %b want 0", ram_stb);
    end
  endtask

  task automatic test_load();
    core_cyc = 1'b1; core_stb = 1'b1; core_we = 1'b0; core_adr = 22'h00555;
    dl_addr = 22'h000002; dl_data = 16'hBEEF; dl_wr = 1'b1;
    @(negedge clk_sys);
    dl_wr = 1'b0;
    #1;
    n_checks++;
    if ({bus, dl_wait} !== {3'b111, 4'b1100, 24'h100000, 32'hBEEFBEEF, 1'b1}) begin
      n_fail++; $display("FAIL load_hi: got %h wait %b want %h wait 1", bus, dl_wait,
                         {3'b111, 4'b1100, 24'h100000, 32'hBEEFBEEF});
    end
    ram_ack = 1'b1;
    #1;
    n_checks++;
    if (core_ack !== 1'b0) begin
      n_fail++; $display("FAIL load_core_stall: got core_ack %b want 0", core_ack);
    end
    @(negedge clk_sys);
    ram_ack = 1'b0;
    #1;
    n_checks++;
    if ({ram_stb, dl_wait} !== 2'b00) begin
      n_fail++; $display("FAIL load_release: got stb/wait %b want 00", {ram_stb, dl_wait});
    end
    dl_addr = 22'h000004; dl_data = 16'h1234; dl_wr = 1'b1;
    @(negedge clk_sys);
    dl_wr = 1'b0;
    #1;
    n_checks++;
    if ({ram_sel, ram_adr, ram_dat, dl_wait} !== {4'b0011, 24'h100001, 32'h12341234, 1'b1}) begin
      n_fail++; $display("FAIL load_lo: got sel %b adr %h dat %h wait %b want 0011 100001 12341234 1",
                         ram_sel, ram_adr, ram_dat, dl_wait);
    end
    dl_addr = 22'h000100; dl_data = 16'hDEAD; dl_wr = 1'b1;
    @(negedge clk_sys);
    dl_wr = 1'b0;
    #1;
    n_checks++;
    if ({ram_stb, ram_adr, ram_dat} !== {1'b1, 24'h100001, 32'h12341234}) begin
      n_fail++; $display("FAIL load_wr_ignored: got stb %b adr %h dat %h want 1 100001 12341234",
                         ram_stb, ram_adr, ram_dat);
    end
    ram_ack = 1'b1;
    @(negedge clk_sys);
    ram_ack = 1'b0;
    @(negedge clk_sys); #1;
    n_checks++;
    if ({ram_stb, core_ack} !== 2'b00) begin
      n_fail++; $display("FAIL load_no_extra: got stb/core_ack %b want 00", {ram_stb, core_ack});
    end
    core_cyc = 1'b0; core_stb = 1'b0;
  endtask

  task automatic test_flush();
    dl_addr = 22'h000006; dl_data = 16'hA5A5; dl_wr = 1'b1;
    @(negedge clk_sys);
    dl_wr = 1'b0; dl_active = 1'b0;
    @(negedge clk_sys);
    @(negedge clk_sys); #1;
    n_checks++;
    if ({bus, dl_wait, rom_loaded} !== {3'b111, 4'b1100, 24'h100001, 32'hA5A5A5A5, 2'b10}) begin
      n_fail++; $display("FAIL flush_hold: got %h wait %b loaded %b want %h 1 0", bus, dl_wait,
                         rom_loaded, {3'b111, 4'b1100, 24'h100001, 32'hA5A5A5A5});
    end
    ram_ack = 1'b1;
    @(negedge clk_sys);
    ram_ack = 1'b0;
    #1;
    n_checks++;
    if ({rom_loaded, dl_wait, ram_stb} !== 3'b100) begin
      n_fail++; $display("FAIL flush_done: got loaded/wait/stb %b want 100",
                         {rom_loaded, dl_wait, ram_stb});
    end
    core_stb = 1'b1; core_cyc = 1'b1; core_adr = 22'h00077;
    #1;
    n_checks++;
    if ({ram_stb, ram_adr} !== {1'b1, 24'h000077}) begin
      n_fail++; $display("FAIL flush_passthru: got stb %b adr %h want 1 000077", ram_stb, ram_adr);
    end
    core_stb = 1'b0; core_cyc = 1'b0;
  endtask

  task automatic test_drain();
    @(negedge clk_sys);
    core_cyc = 1'b1; core_stb = 1'b1; core_we = 1'b0; core_sel = 4'hF;
    core_adr = 22'h00ABC; dl_active = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk_sys); #1;
      n_checks++;
      if ({ram_stb, ram_we, ram_adr, core_ack, dl_wait} !== {2'b10, 24'h000ABC, 1'b0, (k >= 2)}) begin
        n_fail++; $display("FAIL drain_hold[%0d]: got stb/we %b adr %h ack %b wait %b want 10 000ABC 0 %b",
                           k, {ram_stb, ram_we}, ram_adr, core_ack, dl_wait, (k >= 2));
      end
    end
    @(negedge clk_sys);
    ram_ack = 1'b1;
    #1;
    n_checks++;
    if ({core_ack, ram_adr} !== {1'b1, 24'h000ABC}) begin
      n_fail++; $display("FAIL drain_ack: got ack %b adr %h want 1 000ABC", core_ack, ram_adr);
    end
    @(negedge clk_sys);
    ram_ack = 1'b0; core_cyc = 1'b0; core_stb = 1'b0;
    #1;
    n_checks++;
    if ({bus, dl_wait} !== {3'b111, 4'hF, 24'h0, 32'h0, 1'b1}) begin
      n_fail++; $display("FAIL drain_then_erase: got %h wait %b want %h 1", bus, dl_wait,
                         {3'b111, 4'hF, 24'h0, 32'h0});
    end
  endtask

  task automatic test_reset_mid_erase();
    for (int k = 0; k < 2; k++) begin
      ram_ack = 1'b1;
      @(negedge clk_sys);
      ram_ack = 1'b0;
    end
    #1;
    n_checks++;
    if ({ram_stb, ram_adr} !== {1'b1, 24'h000002}) begin
      n_fail++; $display("FAIL mid_erase_adr: got stb %b adr %h want 1 000002", ram_stb, ram_adr);
    end
    core_adr = 22'h03333; core_stb = 1'b0; core_cyc = 1'b0;
    reset_n = 1'b0; dl_active = 1'b0;
    #1;
    n_checks++;
    if ({ram_stb, ram_cyc, ram_adr, dl_wait, rom_loaded} !== {2'b00, 24'h003333, 2'b00}) begin
      n_fail++; $display("FAIL async_reset: got stb/cyc %b adr %h wait %b loaded %b want 00 003333 0 0",
                         {ram_stb, ram_cyc}, ram_adr, dl_wait, rom_loaded);
    end
    @(negedge clk_sys);
    reset_n = 1'b1;
    repeat (2) @(negedge clk_sys);
    dl_active = 1'b1;
    @(negedge clk_sys); #1;
    n_checks++;
    if (ram_stb !== 1'b0) begin
      n_fail++; $display("FAIL restart_latency: got stb %b want 0", ram_stb);
    end
    @(negedge clk_sys); #1;
    n_checks++;
    if (bus !== {3'b111, 4'hF, 24'h0, 32'h0}) begin
      n_fail++; $display("FAIL restart_word0: got %h want %h", bus, {3'b111, 4'hF, 24'h0, 32'h0});
    end
  endtask

  task automatic test_abort_erase();
    dl_active = 1'b0;
    @(negedge clk_sys);
    @(negedge clk_sys); #1;
    n_checks++;
    if ({ram_stb, ram_adr, dl_wait} !== {1'b1, 24'h0, 1'b1}) begin
      n_fail++; $display("FAIL abort_finish: got stb %b adr %h wait %b want 1 000000 1",
                         ram_stb, ram_adr, dl_wait);
    end
    ram_ack = 1'b1;
    @(negedge clk_sys);
    ram_ack = 1'b0;
    #1;
    n_checks++;
    if ({ram_stb, dl_wait, rom_loaded} !== 3'b000) begin
      n_fail++; $display("FAIL abort_idle: got stb/wait/loaded %b want 000",
                         {ram_stb, dl_wait, rom_loaded});
    end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_erase();
    test_load();
    test_flush();
    test_drain();
    test_reset_mid_erase();
    test_abort_erase();
    repeat (2) @(negedge clk_sys);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
